// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU, one bit per cycle: done 32 edges after start
// (1 edge for divide by zero); no backpressure, start is sampled only while idle.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        wr_en
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_op;
  logic [31:0] r_opb;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  logic        w_last;
  logic        w_div_zero;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_nxt;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_div_nxt;
  logic [31:0] w_final;

  // r_acc holds {product_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign w_last      = (r_cnt == 6'd31);
  assign w_div_zero  = (r_opb == 32'd0);
  assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_nxt   = {w_mul_sum, r_acc[31:1]};
  assign w_div_shift = {r_acc[63:32], r_acc[31]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_nxt   = {(w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0]), r_acc[30:0], w_div_ge};

  // Final value as seen through the completing iteration, captured on entry to DONE.
  always_comb begin
    w_final = 32'd0;
    case (r_op)
      2'b00:   w_final = w_mul_nxt[31:0];
      2'b01:   w_final = w_mul_nxt[63:32];
      2'b10:   w_final = w_div_zero ? 32'hFFFF_FFFF : w_div_nxt[31:0];
      default: w_final = w_div_zero ? r_acc[31:0] : w_div_nxt[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = op[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DIV: begin
        busy = 1'b1;
        if (w_div_zero || w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        busy        = 1'b1;
        done        = 1'b1;
        wr_en       = (r_rd_out != 5'd0);
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 2'd0;
      r_opb    <= 32'd0;
      r_acc    <= 64'd0;
      r_cnt    <= 6'd0;
      r_rd     <= 5'd0;
      r_result <= 32'd0;
      r_rd_out <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_opb <= rs2_val;
            r_acc <= {32'd0, rs1_val};
            r_cnt <= 6'd0;
            r_rd  <= rd_in;
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + 6'd1;
        end
        ST_DIV: begin
          if (!w_div_zero) begin
            r_acc <= w_div_nxt;
            r_cnt <= r_cnt + 6'd1;
          end
        end
        default: begin
        end
      endcase
      if (r_state != ST_DONE && w_state_nxt == ST_DONE) begin
        r_result <= w_final;
        r_rd_out <= r_rd;
      end
    end
  end

  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request new operation (sampled in IDLE only).
REQ-006 SHALL have port op, input, 2 bits: 00 MUL (low 32), 01 MULHU (high 32, unsigned), 10 DIVU, 11 REMU.
REQ-007 SHALL have port rs1_val, input, 32 bits: operand A from register file r1out.
REQ-008 SHALL have port rs2_val, input, 32 bits: operand B from register file r2out.
REQ-009 SHALL have port rd_in, input, 5 bits: destination register index.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port result, output, 32 bits: write-back data to register file datawrite.
REQ-013 SHALL have port rd_out, output, 5 bits: destination index for the write-back.
REQ-014 SHALL have port wr_en, output, 1 bit: register-file write enable, equal to done AND (rd_out != 0).

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-016 SHALL, in IDLE with start=1 at a rising edge, latch op, rs1_val, rs2_val and rd_in, clear the iteration counter, and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-017 SHALL ignore start in every state other than IDLE; latched operands SHALL NOT change.
REQ-018 SHALL perform MUL/MULHU as unsigned shift-add, one multiplier bit per cycle, 32 iterations, with a 64-bit product.
REQ-019 SHALL perform DIVU/REMU as restoring division, one quotient bit per cycle, 32 iterations, keeping a 32-bit quotient and a 32-bit remainder.
REQ-020 SHALL use a 6-bit iteration counter and leave MUL/DIV for DONE on the edge completing iteration 32.
REQ-021 SHALL raise done exactly 32 rising edges after the edge that accepted start; done SHALL stay high for one cycle, then the FSM returns to IDLE.
REQ-022 SHALL, for a divide by zero (rs2_val=0 with op[1]=1), skip iteration and enter DONE on the next edge (done 1 edge after start); the result SHALL be 0xFFFFFFFF for DIVU and rs1_val for REMU.
REQ-023 SHALL select the result as product[31:0] for MUL, product[63:32] for MULHU, the quotient for DIVU and the remainder for REMU.
REQ-024 SHALL update result and rd_out only on entry to DONE and hold them stable until the next DONE, so the negedge register-file write sees stable data.
REQ-025 SHALL assert done with wr_en=0 when rd_out=0.
REQ-026 SHALL allow back-to-back operations, so a start in the IDLE cycle following DONE is accepted.

Reset
REQ-027 SHALL, while rst_n=0, immediately force state IDLE, the counter to 0, all internal operand and accumulator registers to 0, and busy=0, done=0, wr_en=0, result=0, rd_out=0.
REQ-028 SHALL abort an in-flight operation on reset with no done pulse, and SHALL accept start normally on the first edge after rst_n rises.

Verification
REQ-029 SHALL pass: MUL, 7 x 6, rd_in=5 -> busy high; 32 edges later done=1, result=42, rd_out=5, wr_en=1 for one cycle.
REQ-030 SHALL pass: MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> result=0x00000001.
REQ-031 SHALL pass: DIVU 100/7 -> result=14; REMU 100/7 -> result=2; each completes in 32 edges.
REQ-032 SHALL pass: DIVU 0x1234/0 -> done after 1 edge, result=0xFFFFFFFF; REMU 0x1234/0 -> result=0x00001234.
REQ-033 SHALL pass: start pulsed with new operands at iteration 10 of a MUL -> ignored, original result correct; separately, rd_in=0 -> done=1, wr_en=0.
REQ-034 SHALL pass: rst_n low at iteration 10 of a DIVU -> busy=0, result=0, no done; a following DIVU 9/3 -> result=3.
